amba_bridge_fsm: RTL and testbench

//  Packet-sequencing controller for the AMBA bridge datapath. Decodes the header address,

---
 rtl/amba_bridge_fsm.sv | 122 ++++++++++++
 tb/tb_amba_bridge_fsm.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/amba_bridge_fsm.sv
// Packet-sequencing controller for the AMBA bridge datapath.
// Decodes the header address, drives the phase strobes and one-hot RAM write enables.
module amba_bridge_fsm #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] ram_full,
  input  logic [NUM_CH-1:0] ram_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_cam,
  output logic [NUM_CH-1:0] write_enb,
  output logic              busy,
  output logic [ADDR_W-1:0] ch_sel
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    RAM_FULL,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t state, next_state;

  logic fullc, emptyc, srst_c;
  logic addr_ok, empty_in;
  logic accept;
  logic wr;

  // Channel lookups by comparison so out-of-range addresses never index past NUM_CH.
  always_comb begin
    fullc    = 1'b0;
    emptyc   = 1'b0;
    srst_c   = 1'b0;
    addr_ok  = 1'b0;
    empty_in = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i)) begin
        fullc  = ram_full[i];
        emptyc = ram_empty[i];
        srst_c = soft_reset[i];
      end
      if (data_in == ADDR_W'(i)) begin
        addr_ok  = 1'b1;
        empty_in = ram_empty[i];
      end
    end
  end

  assign accept = (state == DECODE_ADDRESS) && pkt_valid && addr_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      ch_sel <= '0;
    end else begin
      state <= next_state;
      if (accept) ch_sel <= data_in;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS: begin
        if (accept) next_state = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fullc)           next_state = RAM_FULL;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      end
      RAM_FULL: begin
        if (!fullc) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)           next_state = DECODE_ADDRESS;
        else if (low_packet_valid) next_state = LOAD_PARITY;
        else                       next_state = LOAD_DATA;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fullc ? RAM_FULL : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (emptyc) next_state = LOAD_FIRST_DATA;
      end
      default: next_state = DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && srst_c) next_state = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add  = (state == DECODE_ADDRESS);
    lfd_state   = (state == LOAD_FIRST_DATA);
    ld_state    = (state == LOAD_DATA);
    laf_state   = (state == LOAD_AFTER_FULL);
    full_state  = (state == RAM_FULL);
    rst_int_cam = (state == CHECK_PARITY_ERROR);
    busy        = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    wr          = (state == LOAD_FIRST_DATA) || (state == LOAD_PARITY) ||
                  (state == LOAD_AFTER_FULL) || ((state == LOAD_DATA) && !fullc);
    write_enb   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      write_enb[i] = wr && (ch_sel == ADDR_W'(i));
    end
  end

endmodule

// File: tb/tb_amba_bridge_fsm.sv
// Randomized + directed bench for amba_bridge_fsm against a behavioural phase model.
module tb_amba_bridge_fsm;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              pkt_valid = 1'b0;
  logic [ADDR_W-1:0] data_in = '0;
  logic [NUM_CH-1:0] ram_full = '0;
  logic [NUM_CH-1:0] ram_empty = '1;
  logic [NUM_CH-1:0] soft_reset = '0;
  logic              parity_done = 1'b0;
  logic              low_packet_valid = 1'b0;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_cam, busy;
  logic [NUM_CH-1:0] write_enb;
  logic [ADDR_W-1:0] ch_sel;

  int tests = 0;
  int fails = 0;

  amba_bridge_fsm #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .ram_full(ram_full), .ram_empty(ram_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_cam(rst_int_cam),
    .write_enb(write_enb), .busy(busy), .ch_sel(ch_sel)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: packet phase and selected channel.
  localparam int P_DEC = 0, P_LFD = 1, P_LD = 2, P_LP = 3,
                 P_RF = 4, P_LAF = 5, P_WAIT = 6, P_CPE = 7;
  int m_ph = P_DEC;
  int m_ch = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph <= P_DEC;
      m_ch <= 0;
    end else if (m_ph != P_DEC && soft_reset[m_ch]) begin
      m_ph <= P_DEC;
    end else begin
      case (m_ph)
        P_DEC:
          if (pkt_valid && int'(data_in) < NUM_CH) begin
            m_ch <= int'(data_in);
            m_ph <= ram_empty[data_in] ? P_LFD : P_WAIT;
          end
        P_LFD:  m_ph <= P_LD;
        P_LD:   m_ph <= ram_full[m_ch] ? P_RF : (!pkt_valid ? P_LP : P_LD);
        P_RF:   m_ph <= ram_full[m_ch] ? P_RF : P_LAF;
        P_LAF:  m_ph <= parity_done ? P_DEC : (low_packet_valid ? P_LP : P_LD);
        P_LP:   m_ph <= P_CPE;
        P_CPE:  m_ph <= ram_full[m_ch] ? P_RF : P_DEC;
        P_WAIT: m_ph <= ram_empty[m_ch] ? P_LFD : P_WAIT;
        default: m_ph <= P_DEC;
      endcase
    end
  end

  function automatic logic [5:0] exp_strobes(input int ph);
    return {ph == P_DEC, ph == P_LFD, ph == P_LD, ph == P_LAF, ph == P_RF, ph == P_CPE};
  endfunction

  function automatic logic [NUM_CH-1:0] exp_we(input int ph, input int ch);
    logic writing;
    writing = (ph == P_LFD) || (ph == P_LP) || (ph == P_LAF) ||
              (ph == P_LD && !ram_full[ch]);
    return writing ? NUM_CH'(1 << ch) : '0;
  endfunction

  always @(negedge clock) begin
    check("strobes", 32'({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_cam}),
          32'(exp_strobes(m_ph)));
    check("write_enb", 32'(write_enb), 32'(exp_we(m_ph, m_ch)));
    check("busy", 32'(busy), 32'(!(m_ph == P_DEC || m_ph == P_LD)));
    check("ch_sel", 32'(ch_sel), 32'(m_ch));
  end

  // Literal vectors: {detect,lfd,ld,laf,full,rst_int_cam,busy,any_write}
  localparam logic [7:0] V_DEC  = 8'b100000_0_0, V_LFD = 8'b010000_1_1,
                         V_LD   = 8'b001000_0_1, V_LP  = 8'b000000_1_1,
                         V_RF   = 8'b000010_1_0, V_LAF = 8'b000100_1_1,
                         V_WAIT = 8'b000000_1_0, V_CPE = 8'b000001_1_0;

  task automatic step(input string nm, input logic [7:0] exp);
    @(negedge clock);
    #1;
    check(nm, 32'({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_cam,
                   busy, |write_enb}), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("reset_vec", 32'({detect_add, lfd_state, ld_state, busy, write_enb}), 32'b1_0_0_0_000);
    reset = 1'b0;
    step("reset_release", V_DEC);
    check("reset_ch_sel", 32'(ch_sel), 32'd0);

    // 1: full packet to channel 1
    ram_empty = 3'b111; pkt_valid = 1'b1; data_in = 2'd1;
    step("t1_lfd", V_LFD);
    check("t1_we_lfd", 32'(write_enb), 32'b010);
    for (int i = 0; i < 4; i++) begin
      step("t1_ld", V_LD);
      check("t1_we_ld", 32'(write_enb), 32'b010);
    end
    pkt_valid = 1'b0;
    step("t1_lp", V_LP);
    check("t1_we_lp", 32'(write_enb), 32'b010);
    step("t1_cpe", V_CPE);
    step("t1_dec", V_DEC);

    // 2: wait on a non-empty channel 2
    ram_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
    for (int i = 0; i < 5; i++) step("t2_wait", V_WAIT);
    check("t2_ch_sel", 32'(ch_sel), 32'd2);
    ram_empty = 3'b111;
    step("t2_lfd", V_LFD);
    pkt_valid = 1'b0;
    step("t2_ld", V_LD);
    step("t2_lp", V_LP);
    step("t2_cpe", V_CPE);
    step("t2_dec", V_DEC);

    // 3: channel 0 fills mid-packet
    pkt_valid = 1'b1; data_in = 2'd0;
    step("t3_lfd", V_LFD);
    step("t3_ld", V_LD);
    ram_full = 3'b001;
    for (int i = 0; i < 3; i++) step("t3_rf", V_RF);
    ram_full = 3'b000;
    step("t3_laf", V_LAF);
    check("t3_we_laf", 32'(write_enb), 32'b001);
    step("t3_ld2", V_LD);
    ram_full = 3'b001;
    step("t3_rf2", V_RF);
    ram_full = 3'b000; pkt_valid = 1'b0;
    step("t3_laf2", V_LAF);
    low_packet_valid = 1'b1;
    step("t3_lp", V_LP);
    low_packet_valid = 1'b0;
    step("t3_cpe", V_CPE);
    step("t3_dec", V_DEC);

    // 4: out-of-range address is dropped
    pkt_valid = 1'b1; data_in = 2'd3;
    for (int i = 0; i < 3; i++) step("t4_drop", V_DEC);
    check("t4_ch_sel", 32'(ch_sel), 32'd0);
    pkt_valid = 1'b0;

    // 5: soft reset in LD and in WAIT, non-selected channel ignored
    pkt_valid = 1'b1; data_in = 2'd1;
    step("t5_lfd", V_LFD);
    step("t5_ld", V_LD);
    soft_reset = 3'b001;
    step("t5_ld_other", V_LD);
    soft_reset = 3'b010; pkt_valid = 1'b0;
    step("t5_abort_ld", V_DEC);
    check("t5_ch_kept", 32'(ch_sel), 32'd1);
    soft_reset = 3'b000;
    ram_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
    step("t5_wait", V_WAIT);
    soft_reset = 3'b001;
    step("t5_wait_other", V_WAIT);
    soft_reset = 3'b100; pkt_valid = 1'b0;
    step("t5_abort_wait", V_DEC);
    check("t5_ch_kept2", 32'(ch_sel), 32'd2);
    soft_reset = 3'b000; ram_empty = 3'b111;

    // 6: asynchronous reset in the middle of LOAD_DATA
    pkt_valid = 1'b1; data_in = 2'd0;
    step("t6_lfd", V_LFD);
    step("t6_ld", V_LD);
    #2 reset = 1'b1;
    #1;
    check("t6_async_rst", 32'({detect_add, ld_state, busy, write_enb}), 32'b1_0_0_000);
    pkt_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      pkt_valid        = ($urandom_range(0, 3) != 0);
      data_in          = ADDR_W'($urandom_range(0, 3));
      ram_full         = '0;
      ram_empty        = '0;
      soft_reset       = '0;
      for (int b = 0; b < NUM_CH; b++) begin
        ram_full[b]   = ($urandom_range(0, 5) == 0);
        ram_empty[b]  = ($urandom_range(0, 3) != 0);
        soft_reset[b] = ($urandom_range(0, 31) == 0);
      end
      parity_done      = ($urandom_range(0, 3) == 0);
      low_packet_valid = ($urandom_range(0, 2) == 0);
      reset            = ($urandom_range(0, 399) == 0);
      @(negedge clock);
      #1;
    end
    reset = 1'b0;
    @(negedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
